// File: rtl/vliw_seq.sv
// vliw_seq: program sequencer that issues one VLIW bundle per clock to the matrix unit.
// Optional feature macro: VLIW_SEQ_INV_HALT_EN (stop the run when the unit flags an invalid op).
package mtx_types;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LD_V0 = 4'd1,
    OP_LD_V1 = 4'd2,
    OP_MVMUL = 4'd3,
    OP_VADD  = 4'd4,
    OP_ST_V  = 4'd5,
    OP_SYNC  = 4'd6
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    logic [3:0]  dst;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [15:0] imm;
  } vliw_inst_t;

  typedef struct packed {
    logic busy;
    logic inv;
    logic ovf;
    logic rdy;
  } status_t;

  typedef enum logic [1:0] {
    CT_NORMAL     = 2'd0,
    CT_LOOP_BEGIN = 2'd1,
    CT_LOOP_END   = 2'd2,
    CT_HALT       = 2'd3
  } ctrl_t;
endpackage

module vliw_seq
  import mtx_types::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int AW         = $clog2(PROG_DEPTH),
  parameter int LOOP_W     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_prog_we,
  input  logic [AW-1:0]                 i_prog_addr,
  input  logic [$bits(vliw_inst_t)-1:0] i_prog_inst,
  input  logic [1:0]                    i_prog_ctrl,
  input  logic                          i_start,
  input  logic [AW-1:0]                 i_start_addr,
  input  logic [LOOP_W-1:0]             i_loop_cnt,
  input  logic                          i_stall,
  input  logic                          i_abort,
  input  status_t                       i_unit_st,
  output logic [$bits(vliw_inst_t)-1:0] o_vliw_inst,
  output logic                          o_inst_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [AW-1:0]                 o_pc
);
  localparam int IW = $bits(vliw_inst_t);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            r_state;
  logic [IW+1:0]     r_mem [PROG_DEPTH];
  logic [AW-1:0]     r_pc;
  logic [AW-1:0]     r_loop_addr;
  logic [LOOP_W-1:0] r_loop_ctr;
  logic [IW-1:0]     r_inst;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [IW+1:0]     w_entry;
  ctrl_t             w_ctrl;
  logic [IW-1:0]     w_inst;
  logic [AW-1:0]     w_pc_inc;
  logic [AW-1:0]     w_next_pc;
  logic              w_taken;
  logic              w_wrap;
  logic              w_inv;
  logic              w_unused_st;

  assign w_entry   = r_mem[r_pc];
  assign w_ctrl    = ctrl_t'(w_entry[IW+1:IW]);
  assign w_inst    = w_entry[IW-1:0];
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_taken   = (w_ctrl == CT_LOOP_END) && (r_loop_ctr != '0);
  assign w_next_pc = w_taken ? r_loop_addr : w_pc_inc;
  // Any fall-through from the last entry would wrap; that run ends in error instead.
  assign w_wrap    = (&r_pc) && (w_ctrl != CT_HALT) && !w_taken;

`ifdef VLIW_SEQ_INV_HALT_EN
  assign w_inv = i_unit_st.inv;
`else
  assign w_inv = 1'b0;
`endif
  assign w_unused_st = ^i_unit_st;

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_prog_we && (r_state == S_IDLE))
      r_mem[i_prog_addr] <= {i_prog_ctrl, i_prog_inst};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_loop_addr <= '0;
      r_loop_ctr  <= '0;
      r_inst      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (i_prog_we && (r_state != S_IDLE))
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_pc        <= i_start_addr;
            r_loop_ctr  <= i_loop_cnt;
            r_loop_addr <= i_start_addr;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_inv) begin
            // Enter FIN with done already raised so the pulse lands on the NOP cycle.
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (!i_stall) begin
            r_inst  <= w_inst;
            r_valid <= 1'b1;
            if (w_ctrl == CT_LOOP_BEGIN)
              r_loop_addr <= w_pc_inc;
            if (w_taken)
              r_loop_ctr <= r_loop_ctr - 1'b1;
            if (w_wrap)
              r_err <= 1'b1;
            if ((w_ctrl == CT_HALT) || w_wrap)
              r_state <= S_FIN;
            else
              r_pc <= w_next_pc;
          end
        end

        S_FIN: begin
          if (i_abort || r_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_vliw_inst  = r_inst;
  assign o_inst_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_pc         = r_pc;
endmodule

// File: tb/tb_vliw_seq.sv
// Directed bench for vliw_seq: straight-line stimulus, immediate-assertion checks.
module tb_vliw_seq;
  import mtx_types::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LW    = 8;
  localparam int IW    = $bits(vliw_inst_t);

  logic clk = 1'b0;
  logic rst, prog_we, start, stall, abort;
  logic [AW-1:0] prog_addr, start_addr;
  logic [IW-1:0] prog_inst;
  logic [1:0]    prog_ctrl;
  logic [LW-1:0] loop_cnt;
  status_t       unit_st;
  logic [IW-1:0] vliw_inst;
  logic          inst_valid, busy, done, err;
  logic [AW-1:0] pc_o;

  logic [IW-1:0] exp_mem [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  int seq_loop  [9] = '{8, 9, 10, 11, 10, 11, 10, 11, 12};
  int seq_nolb  [5] = '{20, 21, 20, 21, 22};

  always #5 clk = ~clk;

  vliw_seq #(.PROG_DEPTH(DEPTH), .AW(AW), .LOOP_W(LW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_inst(prog_inst), .i_prog_ctrl(prog_ctrl),
    .i_start(start), .i_start_addr(start_addr), .i_loop_cnt(loop_cnt),
    .i_stall(stall), .i_abort(abort), .i_unit_st(unit_st),
    .o_vliw_inst(vliw_inst), .o_inst_valid(inst_valid), .o_busy(busy),
    .o_done(done), .o_err(err), .o_pc(pc_o)
  );

  function automatic logic [IW-1:0] mk(input opcode_t op, input int n);
    vliw_inst_t b;
    b       = '0;
    b.op    = op;
    b.dst   = 4'(n);
    b.src_a = 4'(n >> 1);
    b.imm   = 16'(n * 3 + 1);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [1:0] c, input opcode_t op);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_ctrl = c;
    prog_inst = mk(op, a);
    exp_mem[a] = mk(op, a);
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Pulse start from the current negedge; returns at the first RUN-cycle negedge.
  task automatic go(input int a, input int lc);
    start      = 1'b1;
    start_addr = AW'(a);
    loop_cnt   = LW'(lc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic exp_bundle(input string tag, input int a);
    @(negedge clk);
    chk($sformatf("%s_inst_a%0d", tag, a), vliw_inst, exp_mem[a]);
    chk($sformatf("%s_valid_a%0d", tag, a), inst_valid, 1);
  endtask

  task automatic exp_nop(input string tag);
    @(negedge clk);
    chk({tag, "_inst"}, vliw_inst, 0);
    chk({tag, "_valid"}, inst_valid, 0);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    prog_addr = '0; start_addr = '0; prog_inst = '0; prog_ctrl = 2'd0;
    loop_cnt = '0; unit_st = '0;
    repeat (2) @(negedge clk);
    chk("rst_inst", vliw_inst, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pc", pc_o, 0);
    rst = 1'b0;

    // program A, loop body at 8..12, loop end without begin at 20..22, tail entries
    wr(0, 2'd0, OP_LD_V0);
    wr(1, 2'd0, OP_MVMUL);
    wr(2, 2'd3, OP_SYNC);
    wr(8, 2'd0, OP_LD_V1);
    wr(9, 2'd1, OP_VADD);
    wr(10, 2'd0, OP_MVMUL);
    wr(11, 2'd2, OP_VADD);
    wr(12, 2'd3, OP_ST_V);
    wr(20, 2'd0, OP_LD_V0);
    wr(21, 2'd2, OP_VADD);
    wr(22, 2'd3, OP_ST_V);
    wr(62, 2'd0, OP_LD_V1);
    wr(63, 2'd0, OP_MVMUL);

    // basic 3-bundle run
    go(0, 0);
    chk("a_busy0", busy, 1);
    chk("a_valid0", inst_valid, 0);
    exp_bundle("a", 0);
    exp_bundle("a", 1);
    exp_bundle("a", 2);
    chk("a_done3", done, 0);
    exp_nop("a_fin");
    chk("a_done4", done, 1);
    chk("a_busy4", busy, 1);
    @(negedge clk);
    chk("a_busy5", busy, 0);
    chk("a_done5", done, 0);
    chk("a_err", err, 0);

    // loop body twice repeated
    go(8, 2);
    foreach (seq_loop[i]) exp_bundle("loop", seq_loop[i]);
    @(negedge clk);
    chk("loop_done", done, 1);
    @(negedge clk);
    chk("loop_busy", busy, 0);

    // stall for three cycles mid-run
    go(8, 0);
    exp_bundle("st", 8);
    exp_bundle("st", 9);
    stall = 1'b1;
    exp_nop("st_s1");
    exp_nop("st_s2");
    exp_nop("st_s3");
    chk("st_pc_held", pc_o, 10);
    stall = 1'b0;
    exp_bundle("st", 10);
    exp_bundle("st", 11);
    exp_bundle("st", 12);
    @(negedge clk);
    chk("st_done", done, 1);
    @(negedge clk);

    // loop end with no loop begin branches back to start_addr
    go(20, 1);
    foreach (seq_nolb[i]) exp_bundle("nolb", seq_nolb[i]);
    @(negedge clk);
    chk("nolb_done", done, 1);
    @(negedge clk);

    // overflow at the last program entry
    go(62, 0);
    exp_bundle("wrap", 62);
    chk("wrap_err1", err, 0);
    exp_bundle("wrap", 63);
    chk("wrap_err2", err, 1);
    chk("wrap_pc", pc_o, 63);
    exp_nop("wrap_fin");
    chk("wrap_done", done, 1);
    @(negedge clk);
    chk("wrap_busy", busy, 0);
    chk("wrap_err_sticky", err, 1);

    // abort on the second RUN cycle; start clears err
    go(0, 0);
    chk("ab_err_clr", err, 0);
    exp_bundle("ab", 0);
    abort = 1'b1;
    exp_nop("ab_nop");
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    abort = 1'b0;
    @(negedge clk);
    chk("ab_done2", done, 0);

    // program write and start while busy
    go(0, 0);
    exp_bundle("wb", 0);
    prog_we = 1'b1; prog_addr = AW'(1); prog_ctrl = 2'd3; prog_inst = 32'hDEAD_BEEF;
    start = 1'b1; start_addr = AW'(20);
    exp_bundle("wb", 1);
    chk("wb_err", err, 1);
    prog_we = 1'b0; start = 1'b0;
    exp_bundle("wb", 2);
    @(negedge clk);
    chk("wb_done", done, 1);
    @(negedge clk);

    // RAM must be unchanged after the ignored write
    go(0, 0);
    exp_bundle("ram", 0);
    exp_bundle("ram", 1);
    exp_bundle("ram", 2);
    repeat (2) @(negedge clk);
    chk("ram_busy", busy, 0);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; start_addr = '0; loop_cnt = '0;
    @(negedge clk);
    start = 1'b0;
    chk("sa_busy", busy, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("sa_busy_off", busy, 0);

    // reset in the middle of a run that has raised err
    go(0, 0);
    prog_we = 1'b1; prog_addr = AW'(5);
    exp_bundle("mr", 0);
    prog_we = 1'b0;
    chk("mr_err", err, 1);
    rst = 1'b1;
    exp_nop("mr_rst");
    chk("mr_busy", busy, 0);
    chk("mr_err0", err, 0);
    chk("mr_pc", pc_o, 0);
    chk("mr_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
